// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencer: merges memory wait, EX redirect and ID data hazard into
// per-stage enables/flushes, squashes the fetch shadow, and keeps stall counters.
module pipe_stage_ctrl #(
    parameter int unsigned SHADOW_CYCLES = 1,
    parameter int unsigned MAX_STALL     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_hazard,
    input  logic        redirect,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_bubble,
    output logic        stall_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [2:0] SHADOW_INIT = 3'(SHADOW_CYCLES);
    localparam logic [7:0] MAX_INIT    = 8'(MAX_STALL);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MWAIT  = 2'd1,
        SHADOW = 2'd2
    } state_t;

    state_t     state;
    state_t     ret_state;
    state_t     eff_state;
    logic [2:0] remaining;
    logic [7:0] stall_run;
    logic [7:0] stall_run_inc;
    logic       mem_wait;
    logic       do_redirect;
    logic       in_shadow;
    logic       do_stall;

    // Leaving MWAIT on ack behaves as the state we froze in, in that same cycle.
    assign mem_wait      = mem_req & ~mem_ack;
    assign eff_state     = (state == MWAIT) ? ret_state : state;
    assign do_redirect   = ~mem_wait & redirect;
    assign in_shadow     = ~mem_wait & ~redirect & (eff_state == SHADOW);
    assign do_stall      = ~mem_wait & ~redirect & (eff_state == RUN) & data_hazard;
    assign stall_run_inc = (stall_run == 8'hFF) ? stall_run : stall_run + 8'd1;

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst_n) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (mem_wait) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (do_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (in_shadow) begin
            if_id_flush = 1'b1;
        end else if (do_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ret_state <= RUN;
            remaining <= 3'd0;
            flush_cnt <= 16'd0;
        end else if (mem_wait) begin
            state <= MWAIT;
            if (state != MWAIT) ret_state <= state;
        end else if (do_redirect) begin
            flush_cnt <= flush_cnt + 16'd1;
            if (SHADOW_INIT != 3'd0) begin
                state     <= SHADOW;
                remaining <= SHADOW_INIT;
            end else begin
                state <= RUN;
            end
        end else if (in_shadow) begin
            remaining <= remaining - 3'd1;
            state     <= (remaining <= 3'd1) ? RUN : SHADOW;
        end else begin
            state <= RUN;
        end
    end

    // Consecutive-stall watchdog: wait cycles hold the run length, others clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= 16'd0;
            stall_run     <= 8'd0;
            stall_timeout <= 1'b0;
        end else if (do_stall) begin
            stall_cnt <= stall_cnt + 16'd1;
            stall_run <= stall_run_inc;
            if (stall_run_inc >= MAX_INIT) stall_timeout <= 1'b1;
        end else if (!mem_wait) begin
            stall_run <= 8'd0;
        end
    end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed test-plan sequences plus random traffic,
// all checked against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_stage_ctrl;

    localparam int SC  = 2;
    localparam int MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_hazard = 1'b0, redirect = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, mem_wb_bubble, stall_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int passed = 0;
    int total  = 0;

    // model state: remaining shadow cycles, counters, consecutive stalls, sticky error
    int m_shadow, m_stall, m_flush, m_consec;
    bit m_to;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, bubble}
    localparam logic [7:0] V_RESET  = 8'b00000111;
    localparam logic [7:0] V_FREEZE = 8'b00001001;
    localparam logic [7:0] V_REDIR  = 8'b11111110;
    localparam logic [7:0] V_SHADOW = 8'b11111100;
    localparam logic [7:0] V_STALL  = 8'b00111010;
    localparam logic [7:0] V_NORMAL = 8'b11111000;

    pipe_stage_ctrl #(.SHADOW_CYCLES(SC), .MAX_STALL(MAX)) dut (
        .clk(clk), .rst_n(rst_n), .data_hazard(data_hazard), .redirect(redirect),
        .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
        .stall_timeout(stall_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs_vec();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, mem_wb_bubble};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_shadow = 0; m_stall = 0; m_flush = 0; m_consec = 0; m_to = 0;
    endtask

    // One clock cycle: drive inputs, check at negedge, advance model, cross posedge.
    task automatic step(input logic hz, input logic rd, input logic mq, input logic ma);
        logic [7:0] exp;
        data_hazard = hz; redirect = rd; mem_req = mq; mem_ack = ma;
        @(negedge clk);
        chk("stall_cnt", stall_cnt, 16'(m_stall));
        chk("flush_cnt", flush_cnt, 16'(m_flush));
        chk("timeout", {15'd0, stall_timeout}, {15'd0, m_to});
        if (mq && !ma) begin
            exp = V_FREEZE;
        end else if (rd) begin
            exp = V_REDIR;
            m_flush = (m_flush + 1) % 65536;
            m_shadow = SC;
            m_consec = 0;
        end else if (m_shadow > 0) begin
            exp = V_SHADOW;
            m_shadow--;
            m_consec = 0;
        end else if (hz) begin
            exp = V_STALL;
            m_stall = (m_stall + 1) % 65536;
            if (m_consec < 255) m_consec++;
            if (m_consec >= MAX) m_to = 1;
        end else begin
            exp = V_NORMAL;
            m_consec = 0;
        end
        chk("ctrl", {8'd0, obs_vec()}, {8'd0, exp});
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; released so the next posedge runs.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ctrl", {8'd0, obs_vec()}, {8'd0, V_RESET});
        chk("rst_timeout", {15'd0, stall_timeout}, 16'd0);
        chk("rst_stall_cnt", stall_cnt, 16'd0);
        chk("rst_flush_cnt", flush_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // data stall, 3 cycles, then stall_cnt = 3
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("stall3", stall_cnt, 16'd3);

        // redirect with 2-cycle shadow; hazard in shadow is ignored
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("flush1", flush_cnt, 16'd1);

        // mem wait with redirect held across it
        repeat (3) step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        step(0, 0, 0, 0);
        chk("flush_once", flush_cnt, 16'd2);
        repeat (2) step(0, 0, 0, 0);

        // priority: hazard + redirect together
        step(1, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);

        // wait entered during shadow keeps the remaining count
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // watchdog: stalls interrupted by mem waits still count consecutively
        repeat (7) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        repeat (MAX - 7) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wd_sticky", {15'd0, stall_timeout}, 16'd1);
        do_reset();
        step(0, 0, 0, 0);

        // watchdog just below threshold does not fire
        repeat (MAX - 1) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // reset mid-MWAIT and mid-SHADOW discards state
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));

        // stall counter wrap
        do_reset();
        repeat (65535) step(1, 0, 0, 0);
        chk("wrap_ffff", stall_cnt, 16'hFFFF);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("wrap_0000", stall_cnt, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Central sequencer for the 5-stage RISC-V pipeline. It merges three inputs into one consistent set of per-stage register enables and flushes each cycle: the ID-stage data-hazard stall request, the EX-stage taken branch/jump redirect, and the data-memory wait. It also squashes the wrong-path fetch shadow after a redirect and keeps stall/flush performance counters plus a stall watchdog. It sits beside the hazard detection unit and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- SHADOW_CYCLES, 1: cycles of IF/ID squash after a redirect, covering synchronous IROM latency (0..7).
- MAX_STALL, 15: consecutive data-stall cycles tolerated before the watchdog fires (1..255).
- clk  in  1  core clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- data_hazard  in  1  ID instruction has an unresolved RAW dependence.
- redirect  in  1  EX instruction is a taken branch, JAL or JALR. Level signal, held while EX is held.
- mem_req  in  1  MEM instruction is a load or store.
- mem_ack  in  1  data memory completes the MEM access this cycle.
- pc_en  out  1  PC register loads its next value.
- if_id_en / id_ex_en / ex_mem_en / mem_wb_en  out  1 each  pipeline register enables.
- if_id_flush / id_ex_flush / mem_wb_bubble  out  1 each  load a NOP/bubble in place of data.
- stall_timeout  out  1  sticky watchdog error.
- stall_cnt  out  16  data-stall cycle count, wraps.
- flush_cnt  out  16  redirect event count, wraps.

## Operation
- FSM states: RUN, MWAIT, SHADOW. The reset state is RUN.
- Outputs are combinational from state and inputs. The evaluation priority is mem wait > redirect > data_hazard > normal.
- **Mem wait.** Condition: mem_req=1 and mem_ack=0, in any state.
  - pc_en, if_id_en, id_ex_en and ex_mem_en are 0. mem_wb_en=1 with mem_wb_bubble=1.
  - Next state is MWAIT. The SHADOW remaining count is held.
- **MWAIT exit.** On mem_ack=1, return to the state that was active before the wait (RUN or SHADOW).
  - That same cycle, normal priority applies to the remaining inputs.
- **Redirect.** Condition: not waiting and redirect=1.
  - pc_en=1 (loads target), if_id_flush=1, id_ex_flush=1. All other enables are 1.
  - data_hazard is ignored. flush_cnt increments.
  - If SHADOW_CYCLES>0, next state is SHADOW with remaining=SHADOW_CYCLES; otherwise next state is RUN.
- **SHADOW.**
  - pc_en=1 and if_id_flush=1. All enables are 1.
  - data_hazard is ignored, because ID holds a bubble.
  - remaining decrements; go to RUN when it reaches 0.
  - A redirect while in SHADOW reloads remaining=SHADOW_CYCLES.
- **Data stall.** Condition: in RUN, not waiting, no redirect, data_hazard=1.
  - pc_en=0 and if_id_en=0. id_ex_en=1 with id_ex_flush=1. ex_mem_en=1 and mem_wb_en=1.
  - stall_cnt increments.
- **Normal.** All enables are 1 and all flush/bubble outputs are 0.
- **Watchdog.** A consecutive data-stall counter is 8-bit, saturating.
  - It is cleared by any cycle without a data stall. Mem-wait cycles hold it.
  - When the counter reaches MAX_STALL, stall_timeout sets and stays set until reset.
- Counters are 16-bit and wrap from 0xFFFF to 0x0000.

## Timing
- While rst_n=0:
  - all enables are 0;
  - if_id_flush, id_ex_flush and mem_wb_bubble are 1;
  - stall_timeout=0, stall_cnt=0, flush_cnt=0.
- Reset asserts asynchronously. Deassertion takes effect at the next posedge, in state RUN.
- Reset mid-MWAIT or mid-SHADOW discards the state and the remaining count.
- Control latency is 0 cycles: outputs react in the same cycle the inputs change.
- State, counters and the watchdog update at posedge.
- mem_ack in the same cycle as mem_req means no wait is entered. Waits have no upper bound.
- Redirect is sampled only in non-wait cycles, so a redirect held during MWAIT fires exactly once, on the release cycle.
- stall_cnt and flush_cnt values are visible the cycle after the event.

## Test plan
- **Data stall.** Hold data_hazard=1 for 3 cycles in RUN.
  - Expect pc_en=0 and if_id_en=0 for exactly 3 cycles, id_ex_flush=1 for 3 cycles, then stall_cnt=3.
- **Redirect with shadow.** Pulse redirect for 1 cycle with SHADOW_CYCLES=2.
  - Expect if_id_flush=1 for 3 cycles and id_ex_flush=1 for 1 cycle, then flush_cnt=1 and the FSM back in RUN.
- **Mem wait with redirect held.** Assert mem_req for 4 cycles with mem_ack rising on the 4th, while redirect is held.
  - Expect 3 freeze cycles with mem_wb_bubble=1, then the redirect flush on cycle 4, and flush_cnt incremented exactly once.
- **Priority.** Assert data_hazard and redirect together.
  - Expect redirect outputs only, with stall_cnt unchanged.
- **Watchdog.** Hold data_hazard for MAX_STALL=15 cycles.
  - Expect stall_timeout rising after the 15th stall cycle and staying 1 after data_hazard drops.
  - Expect rst_n low mid-sequence to clear it asynchronously.
- **Counter wrap.** Preload stall_cnt near wrap via a long stall run.
  - Expect 0xFFFF followed by 0x0000.
